// File: rtl/descramble_frame_ctrl_pkg.sv
// Shared definitions for the descrambler framing controller: state
// encodings, counter widths and the LFSR seed loaded on lfsr_load.
package descramble_frame_ctrl_pkg;

  localparam int CNT_W = 8;
  localparam int RUN_W = 4;

  // The external 3-bit descrambler reloads this value on lfsr_load.
  localparam logic [2:0] LFSR_SEED = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HUNT    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GUARD   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/descramble_frame_ctrl_preamble_hunter.sv
// Counts consecutive 1 bits on the qualified serial input and flags the
// bit that completes a PRE_LEN-long run of ones.
module descramble_frame_ctrl_preamble_hunter
  import descramble_frame_ctrl_pkg::*;
#(
  parameter int PRE_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_bit_en,
  input  logic i_din,
  output logic o_detect
);

  localparam logic [RUN_W-1:0] PRE_LAST = RUN_W'(PRE_LEN - 1);

  logic [RUN_W-1:0] r_run_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_run_cnt <= '0;
    end else if (i_bit_en) begin
      if (!i_din) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt != '1) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end
  end

  // Detect is combinational so the FSM can enter LOAD on the same edge.
  assign o_detect = !i_clear && i_bit_en && i_din && (r_run_cnt >= PRE_LAST);

endmodule

// File: rtl/descramble_frame_ctrl.sv
// Framing controller for the serial PRBS descrambler: hunts the all-ones
// preamble, then frames payload windows separated by guard gaps.
//   state   | meaning
//   IDLE    | waiting for enable
//   HUNT    | looking for PRE_LEN consecutive ones
//   LOAD    | one cycle, descrambler reloads its seed
//   PAYLOAD | payload bits stepped through the descrambler
//   GUARD   | GAP_LEN guard bits, LFSR frozen
//   DONE    | one cycle, burst of FRAMES frames complete
module descramble_frame_ctrl
  import descramble_frame_ctrl_pkg::*;
#(
  parameter int PRE_LEN           = 4,
  parameter int PAY_LEN           = 10,
  parameter int GAP_LEN           = 3,
  parameter int FRAMES            = 4,
  parameter int RESEED_EACH_FRAME = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_abort,
  input  logic             i_bit_en,
  input  logic             i_din,
  output logic             o_lfsr_load,
  output logic             o_lfsr_step,
  output logic             o_payload_valid,
  output logic             o_frame_start,
  output logic             o_frame_end,
  output logic             o_burst_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [2:0]       o_state
);

  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAY_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] FRAMES_C  = CNT_W'(FRAMES);
  localparam bit               HAS_GAP   = (GAP_LEN > 0);
  localparam bit               HAS_LIMIT = (FRAMES != 0);
  localparam bit               RESEED    = (RESEED_EACH_FRAME != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_lfsr_load;
  logic             r_burst_done;
  logic             r_busy;

  logic w_detect;
  logic w_hunt_clear;
  logic w_accept;
  logic w_last_bit;
  logic w_last_frame;

  assign w_hunt_clear = (r_state != ST_HUNT) || i_abort;

  descramble_frame_ctrl_preamble_hunter #(
    .PRE_LEN (PRE_LEN)
  ) u_hunter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_hunt_clear),
    .i_bit_en (i_bit_en),
    .i_din    (i_din),
    .o_detect (w_detect)
  );

  assign w_accept     = (r_state == ST_PAYLOAD) && i_bit_en;
  assign w_last_bit   = (r_bit_cnt == PAY_LAST);
  assign w_last_frame = HAS_LIMIT && ((r_frame_cnt + 8'd1) == FRAMES_C);

  always_ff @(posedge i_clk) begin
    r_lfsr_load  <= 1'b0;
    r_burst_done <= 1'b0;
    if (i_rst || i_abort) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_frame_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_state     <= ST_HUNT;
            r_busy      <= 1'b1;
            r_frame_cnt <= '0;
          end
        end
        ST_HUNT: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_detect) begin
            r_state     <= ST_LOAD;
            r_lfsr_load <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (i_bit_en) begin
            if (w_last_bit) begin
              r_bit_cnt   <= '0;
              r_frame_cnt <= r_frame_cnt + 8'd1;
              if (w_last_frame) begin
                r_state      <= ST_DONE;
                r_burst_done <= 1'b1;
              end else if (!i_enable) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else if (HAS_GAP) begin
                r_state <= ST_GUARD;
              end else if (RESEED) begin
                r_state     <= ST_LOAD;
                r_lfsr_load <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end
        ST_GUARD: begin
          if (i_bit_en) begin
            if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt <= '0;
              if (RESEED) begin
                r_state     <= ST_LOAD;
                r_lfsr_load <= 1'b1;
              end else begin
                r_state <= ST_PAYLOAD;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt + 8'd1;
            end
          end
        end
        ST_DONE: begin
          r_frame_cnt <= '0;
          if (i_enable) begin
            r_state <= ST_HUNT;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_lfsr_load     = r_lfsr_load;
  assign o_burst_done    = r_burst_done;
  assign o_busy          = r_busy;
  assign o_frame_cnt     = r_frame_cnt;
  assign o_state         = r_state;
  assign o_lfsr_step     = w_accept;
  assign o_payload_valid = w_accept;
  assign o_frame_start   = w_accept && (r_bit_cnt == '0);
  assign o_frame_end     = w_accept && w_last_bit;

endmodule

// File: tb/tb_descramble_frame_ctrl.sv
// Bench for descramble_frame_ctrl: two configurations driven from the same
// stimulus, checked against a bit-position model plus directed sequences.
module tb_descramble_frame_ctrl;

  localparam int PAY = 10;
  localparam int PH_OFF = 0, PH_SEEK = 1, PH_FRAME = 2, PH_CLOSE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, ab = 1'b0, ben = 1'b0, din = 1'b0;

  logic a_load, a_step, a_valid, a_start, a_end, a_done, a_busy;
  logic b_load, b_step, b_valid, b_start, b_end, b_done, b_busy;
  logic [7:0] a_cnt, b_cnt;
  logic [2:0] a_st, b_st;
  logic [17:0] a_vec, b_vec;

  assign a_vec = {a_load, a_step, a_valid, a_start, a_end, a_done, a_busy, a_cnt, a_st};
  assign b_vec = {b_load, b_step, b_valid, b_start, b_end, b_done, b_busy, b_cnt, b_st};

  descramble_frame_ctrl #(.PRE_LEN(4), .PAY_LEN(PAY), .GAP_LEN(3), .FRAMES(4),
                          .RESEED_EACH_FRAME(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_abort(ab), .i_bit_en(ben), .i_din(din),
    .o_lfsr_load(a_load), .o_lfsr_step(a_step), .o_payload_valid(a_valid),
    .o_frame_start(a_start), .o_frame_end(a_end), .o_burst_done(a_done),
    .o_busy(a_busy), .o_frame_cnt(a_cnt), .o_state(a_st));

  descramble_frame_ctrl #(.PRE_LEN(4), .PAY_LEN(PAY), .GAP_LEN(0), .FRAMES(2),
                          .RESEED_EACH_FRAME(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_abort(ab), .i_bit_en(ben), .i_din(din),
    .o_lfsr_load(b_load), .o_lfsr_step(b_step), .o_payload_valid(b_valid),
    .o_frame_start(b_start), .o_frame_end(b_end), .o_burst_done(b_done),
    .o_busy(b_busy), .o_frame_cnt(b_cnt), .o_state(b_st));

  int n_cmp = 0, n_bad = 0, n_print = 0, cyc = 0;

  // Reference model: framing is tracked as a running accepted-bit position
  // folded modulo the frame period, hunting as a history of accepted bits.
  int          m_phase [2];
  int          m_pos   [2];
  int          m_done  [2];
  bit          m_skip  [2];
  int unsigned m_hist  [2];

  function automatic int gap_of(int k); return (k == 0) ? 3 : 0; endfunction
  function automatic int fr_of(int k);  return (k == 0) ? 4 : 2; endfunction
  function automatic bit rs_of(int k);  return (k == 0) ? 1'b0 : 1'b1; endfunction

  function automatic logic [17:0] expect_out(int k, bit b);
    logic ld = 1'b0, sp = 1'b0, fs = 1'b0, fe = 1'b0, bd = 1'b0, bz = 1'b1;
    logic [2:0] s = 3'd0;
    int idx;
    case (m_phase[k])
      PH_OFF:  begin bz = 1'b0; s = 3'd0; end
      PH_SEEK: s = 3'd1;
      PH_FRAME: begin
        if (m_skip[k]) begin
          s = 3'd2; ld = 1'b1;
        end else begin
          idx = m_pos[k] % (PAY + gap_of(k));
          if (idx < PAY) begin
            s = 3'd3; sp = b; fs = b && (idx == 0); fe = b && (idx == PAY - 1);
          end else begin
            s = 3'd4;
          end
        end
      end
      default: begin s = 3'd5; bd = 1'b1; end
    endcase
    return {ld, sp, sp, fs, fe, bd, bz, 8'(m_done[k]), s};
  endfunction

  task automatic model_update(input int k);
    int idx;
    if (rst || ab) begin
      m_phase[k] = PH_OFF; m_done[k] = 0; m_pos[k] = 0; m_skip[k] = 1'b0;
      return;
    end
    case (m_phase[k])
      PH_OFF: if (en) begin m_phase[k] = PH_SEEK; m_hist[k] = 0; m_done[k] = 0; end
      PH_SEEK: begin
        if (!en) m_phase[k] = PH_OFF;
        else if (ben) begin
          m_hist[k] = (m_hist[k] << 1) | 32'(din);
          if ((m_hist[k] & 32'hF) == 32'hF) begin
            m_phase[k] = PH_FRAME; m_skip[k] = 1'b1; m_pos[k] = 0;
          end
        end
      end
      PH_FRAME: begin
        if (m_skip[k]) m_skip[k] = 1'b0;
        else if (ben) begin
          idx = m_pos[k] % (PAY + gap_of(k));
          m_pos[k]++;
          if (idx == PAY - 1) begin
            m_done[k]++;
            if (fr_of(k) != 0 && m_done[k] == fr_of(k)) m_phase[k] = PH_CLOSE;
            else if (!en) m_phase[k] = PH_OFF;
            else if (gap_of(k) == 0 && rs_of(k)) m_skip[k] = 1'b1;
          end else if (gap_of(k) > 0 && idx == PAY + gap_of(k) - 1 && rs_of(k)) begin
            m_skip[k] = 1'b1;
          end
        end
      end
      default: begin
        m_phase[k] = en ? PH_SEEK : PH_OFF; m_hist[k] = 0; m_done[k] = 0;
      end
    endcase
  endtask

  task automatic check_model(input int k);
    logic [17:0] got, exp;
    got = (k == 0) ? a_vec : b_vec;
    exp = expect_out(k, ben);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL model_dut%0d cycle %0d: got %05h expected %05h", k, cyc, got, exp);
      end
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick(input bit cmp);
    #1;
    if (cmp) begin check_model(0); check_model(1); end
    @(posedge clk);
    model_update(0);
    model_update(1);
    cyc++;
    #1;
  endtask

  task automatic preamble();
    rst = 1'b1; ab = 1'b0; en = 1'b1; ben = 1'b0; din = 1'b0; tick(1);
    rst = 1'b0; tick(1);
    for (int i = 0; i < 4; i++) begin ben = 1'b1; din = 1'b1; tick(1); end
    ben = 1'b0; din = 1'b0; tick(1);
  endtask

  typedef struct {
    bit       en;
    bit       ben;
    bit       din;
    bit [2:0] st;
    bit       load;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n_step, n_start, n_end, n_done, n_load_b, n_step_b, n_done_b;
    int first_end, done_at, cnt_at_done, acc, acc_at_end, stray;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1};

    // Reset state
    tick(0);
    tick(1);
    chk("reset_vec_a", int'(a_vec), 0);
    chk("reset_vec_b", int'(b_vec), 0);
    rst = 1'b0;

    // Preamble match from the vector table
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; ben = tbl[i].ben; din = tbl[i].din;
      #1;
      chk($sformatf("pre_state_row%0d", i), int'(a_st), int'(tbl[i].st));
      chk($sformatf("pre_load_row%0d", i), int'(a_load), int'(tbl[i].load));
      chk($sformatf("pre_load_b_row%0d", i), int'(b_load), int'(tbl[i].load));
      tick(1);
    end

    // Full burst with bit_en every cycle
    n_step = 0; n_start = 0; n_end = 0; n_done = 0; n_load_b = 0; n_step_b = 0; n_done_b = 0;
    first_end = -1; done_at = -1; cnt_at_done = -1;
    for (int c = 0; c < 60; c++) begin
      ben = 1'b1; din = 1'b0;
      #1;
      n_step += int'(a_step); n_start += int'(a_start); n_done += int'(a_done);
      n_load_b += int'(b_load); n_step_b += int'(b_step); n_done_b += int'(b_done);
      if (a_end) begin
        chk($sformatf("end_cycle_frame%0d", n_end), c, n_end * 13 + 9);
        n_end++;
      end
      if (a_done) begin done_at = c; cnt_at_done = int'(a_cnt); end
      tick(1);
    end
    chk("burst_steps", n_step, 40);
    chk("burst_starts", n_start, 4);
    chk("burst_ends", n_end, 4);
    chk("burst_done_pulses", n_done, 1);
    chk("burst_done_cycle", done_at, 49);
    chk("frame_cnt_at_done", cnt_at_done, 4);
    chk("b_mid_loads", n_load_b, 1);
    chk("b_steps", n_step_b, 20);
    chk("b_done_pulses", n_done_b, 1);

    // Sparse bit_en
    preamble();
    acc = 0; acc_at_end = -1; stray = 0;
    for (int c = 0; c < 60; c++) begin
      ben = (c % 3 == 0); din = 1'b0;
      #1;
      if (a_valid) acc++;
      if (a_end && acc_at_end < 0) acc_at_end = acc;
      if (!ben && (a_step || a_valid || a_start || a_end)) stray++;
      tick(1);
    end
    chk("sparse_end_bit", acc_at_end, 10);
    chk("sparse_stray_strobes", stray, 0);

    // enable drop during frame 2, bit 5
    preamble();
    n_end = 0; n_done = 0;
    for (int c = 0; c < 40; c++) begin
      ben = 1'b1; din = 1'b0;
      if (c == 17) en = 1'b0;
      #1;
      if (c >= 17) n_end += int'(a_end);
      n_done += int'(a_done);
      if (c == 23) begin
        chk("drop_state_after", int'(a_st), 0);
        chk("drop_cnt_after", int'(a_cnt), 2);
      end
      tick(1);
    end
    chk("drop_frame2_end", n_end, 1);
    chk("drop_no_done", n_done, 0);
    chk("drop_cnt_idle", int'(a_cnt), 2);
    chk("drop_busy_idle", int'(a_busy), 0);

    // abort and reset mid-payload at bit 4, then no re-trigger without preamble
    for (int pass = 0; pass < 2; pass++) begin
      preamble();
      for (int c = 0; c < 5; c++) begin
        ben = 1'b1; din = 1'b0;
        if (pass == 0) ab = (c == 3); else rst = (c == 3);
        #1;
        if (c == 4) begin
          chk($sformatf("kill%0d_state", pass), int'(a_st), 0);
          chk($sformatf("kill%0d_strobes", pass), int'({a_step, a_valid, a_start, a_end}), 0);
          chk($sformatf("kill%0d_done", pass), int'(a_done), 0);
          chk($sformatf("kill%0d_cnt", pass), int'(a_cnt), 0);
        end
        tick(1);
      end
      n_load_b = 0;
      for (int c = 0; c < 20; c++) begin
        ben = 1'b1; din = 1'b0;
        #1;
        n_load_b += int'(a_load);
        tick(1);
      end
      chk($sformatf("kill%0d_no_reload", pass), n_load_b, 0);
      chk($sformatf("kill%0d_hunting", pass), int'(a_st), 1);
    end

    // Randomised stimulus against the model
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      ab  = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 99) != 0);
      ben = ($urandom_range(0, 3) != 0);
      din = ($urandom_range(0, 4) != 0);
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/descramble_frame_ctrl.md
Name: descramble_frame_ctrl

Overview:
- Sequencing controller for the serial PRBS descrambler datapath: hunts for an all-ones preamble on the serial input, then frames the following bit stream into payload windows separated by guard gaps.
- Drives the load, step and valid strobes of an external 3-bit LFSR/XOR descrambler.
- Sits between the serial receive pin logic and the descrambler; the descrambler itself stays free of control logic.

Parameters:
- PRE_LEN, 4: consecutive 1 bits that form the preamble (1..15)
- PAY_LEN, 10: payload bits per frame (1..255)
- GAP_LEN, 3: guard bits between frames (0..255)
- FRAMES, 4: frames per burst; 0 = unlimited, until enable drops or abort
- RESEED_EACH_FRAME, 0: 1 = pulse lfsr_load before every frame; 0 = only after the preamble

Ports:
- CLK  in  1  system clock; all state updates on posedge
- RST  in  1  synchronous, active-high reset
- enable  in  1  level; permits hunting and framing
- abort  in  1  pulse; forces IDLE on the next edge
- bit_en  in  1  qualifies din; one serial bit per asserted cycle
- din  in  1  serial received bit
- lfsr_load  out  1  one-cycle pulse; descrambler reloads its seed
- lfsr_step  out  1  advance the LFSR this cycle
- payload_valid  out  1  din is a payload bit this cycle
- frame_start  out  1  first payload bit of a frame
- frame_end  out  1  last payload bit of a frame
- burst_done  out  1  one-cycle pulse when FRAMES frames have completed
- busy  out  1  state is not IDLE
- frame_cnt  out  8  frames completed in the current burst
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (RST=1 at posedge):
  - state goes to IDLE; all counters clear.
  - lfsr_load, burst_done, busy and frame_cnt are 0.
  - The combinational strobes are 0 because the state is IDLE.
  - Reset applied mid-burst discards the frame in progress and does not pulse burst_done.
- States:
  - IDLE: enable=1 moves to HUNT on the next edge.
  - HUNT: on each bit_en, run_cnt increments if din=1 and clears to 0 if din=0.
    - When the bit that makes run_cnt==PRE_LEN is accepted, move to LOAD.
    - The run counter saturates; extra 1s do not matter because the state leaves HUNT.
  - LOAD: exactly one cycle, regardless of bit_en.
    - lfsr_load=1 for that cycle (registered).
    - A bit presented during LOAD is not consumed as payload. Upstream must not present payload in the cycle immediately after the last preamble bit.
    - Moves to PAYLOAD.
  - PAYLOAD: combinational outputs, qualified by bit_en:
    - payload_valid = lfsr_step = bit_en.
    - frame_start = bit_en & (bit_cnt==0).
    - frame_end = bit_en & (bit_cnt==PAY_LEN-1).
    - bit_cnt increments per accepted bit.
    - On the frame_end bit: frame_cnt increments and bit_cnt clears.
    - Next state after the frame_end bit:
      - DONE if FRAMES≠0 and frame_cnt+1==FRAMES;
      - otherwise IDLE if enable=0;
      - otherwise GUARD if GAP_LEN>0;
      - otherwise PAYLOAD directly (LOAD instead if RESEED_EACH_FRAME=1).
  - GUARD: counts GAP_LEN accepted bits with no strobes; the LFSR does not step.
    - After the GAP_LEN-th bit, go to LOAD if RESEED_EACH_FRAME=1, else PAYLOAD.
  - DONE: one cycle; burst_done=1 (registered).
    - Next state: HUNT if enable=1, else IDLE.
    - frame_cnt clears on exit.
- enable deasserted mid-frame: the current frame completes, then IDLE. burst_done pulses only on FRAMES completion.
- abort: highest priority after RST. Next edge forces IDLE and clears counters; no burst_done.
- Latency:
  - Preamble completion to lfsr_load: 1 cycle.
  - The first payload bit is accepted on any bit_en at or after cycle +2.
- Width rules:
  - bit_cnt and gap_cnt are 8 bits; run_cnt is 4 bits.
  - frame_cnt wraps modulo 256 when FRAMES=0.
- Encoding: IDLE=0, HUNT=1, LOAD=2, PAYLOAD=3, GUARD=4, DONE=5. Unused encodings go to IDLE.

Decomposition:
- Shared package:
  - state encodings (IDLE..DONE);
  - the LFSR seed constant 3'b111, used by the descrambler on lfsr_load;
  - counter width constants.
- One sub-module, preamble_hunter: holds the run counter, takes din/bit_en/clear, and outputs a one-cycle detect pulse.

Test Plan:
- Preamble match: RST, enable=1, din 0,1,1,0,1,1,1,1 on consecutive bit_en -> a single lfsr_load pulse one cycle after the 8th bit. The 1,1,0 prefix must not trigger.
- Frame timing: after the preamble, 40 bits with bit_en=1 every cycle -> 4 frames of payload_valid for 10 cycles each, 3-cycle gaps, frame_start/frame_end on cycles 1 and 10 of each frame. frame_cnt runs 1..4 and burst_done pulses once; 40 lfsr_step pulses total.
- Sparse bit_en: bit_en every 3rd cycle -> strobes appear only on bit_en cycles and frame_end falls on the 10th accepted bit.
- GAP_LEN=0, RESEED_EACH_FRAME=1: frames are back-to-back with a LOAD cycle (lfsr_load=1, no strobes) between them.
- enable drop during frame 2 at bit 5 -> frame 2 completes (frame_end seen), then IDLE with no burst_done; frame_cnt=2 while in IDLE.
- Abort/RST mid-payload at bit 4 -> next edge state_o=0, all strobes 0, no burst_done. A re-enable requires a new preamble.
